// File: rtl/fht_ram_loader_pkg.sv
// Shared definitions for the FHT RAM loader: default sample/address widths,
// frame length and the loader FSM state encoding.
package fht_pkg;

  localparam int D_BIT_DEF = 17;
  localparam int A_BIT_DEF = 8;
  localparam int N_DEF     = 4 * (2 ** A_BIT_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fht_ram_loader_if.sv
// Sample-stream and four-bank RAM write bus of the FHT RAM loader.
// master: the side feeding samples and consuming RAM writes (testbench/system).
// slave : the loader itself.
interface fht_ram_loader_if #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8
);

  logic             iSTART;
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             oBUSY;
  logic             oDONE;
  logic [D_BIT-1:0] oDATA_0;
  logic [D_BIT-1:0] oDATA_1;
  logic [D_BIT-1:0] oDATA_2;
  logic [D_BIT-1:0] oDATA_3;
  logic [A_BIT-1:0] oADDR_WR_0;
  logic [A_BIT-1:0] oADDR_WR_1;
  logic [A_BIT-1:0] oADDR_WR_2;
  logic [A_BIT-1:0] oADDR_WR_3;
  logic             oWE_0;
  logic             oWE_1;
  logic             oWE_2;
  logic             oWE_3;

  modport master (
    output iSTART, iDATA, iVALID,
    input  oREADY, oBUSY, oDONE,
    input  oDATA_0, oDATA_1, oDATA_2, oDATA_3,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oWE_0, oWE_1, oWE_2, oWE_3
  );

  modport slave (
    input  iSTART, iDATA, iVALID,
    output oREADY, oBUSY, oDONE,
    output oDATA_0, oDATA_1, oDATA_2, oDATA_3,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oWE_0, oWE_1, oWE_2, oWE_3
  );

endinterface

// File: rtl/fht_ram_loader_bitrev.sv
// Combinational index reorder for the FHT loader. With REV_EN set the output
// is the bit-reverse of the input over W bits; otherwise it passes through
// unchanged, so the loader keeps identical timing in both address modes.
module fht_bitrev #(
  parameter int W      = 10,
  parameter bit REV_EN = 1'b1
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  // Mirror bit i to position W-1-i when reversal is enabled.
  always_comb begin
    out_o = in_i;
    if (REV_EN) begin
      for (int i = 0; i < W; i++) begin
        out_o[i] = in_i[W-1-i];
      end
    end
  end

endmodule

// File: rtl/fht_ram_loader.sv
// FHT RAM loader: accepts a frame of N = 4*2^A_BIT natural-order samples and
// scatters them over four RAM banks. Each accepted sample is written one cycle
// later to bank idx[1:0], address idx[A_BIT+1:2], where idx is the sample
// counter, bit-reversed when FHT_LOADER_BITREV_EN is defined and taken in
// natural order otherwise.
module fht_ram_loader
  import fht_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
) (
  input logic            iCLK,
  input logic            iRESET,
  fht_ram_loader_if.slave bus
);

  localparam int NW = A_BIT + 2;
  localparam logic [NW-1:0] N_LAST = '1;  // index of the final sample, N-1

`ifdef FHT_LOADER_BITREV_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  state_e           state_q;
  logic [NW-1:0]    n_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       we_q;
  logic [D_BIT-1:0] data_q [4];
  logic [A_BIT-1:0] addr_q [4];

  logic [NW-1:0]    idx_d;
  logic [1:0]       bank_d;
  logic [A_BIT-1:0] addr_d;
  logic [3:0]       we_d;
  logic             accept_d;

  fht_bitrev #(
    .W      (NW),
    .REV_EN (REV_EN)
  ) u_bitrev (
    .in_i  (n_q),
    .out_o (idx_d)
  );

  assign bank_d   = idx_d[1:0];
  assign addr_d   = idx_d[NW-1:2];
  assign accept_d = bus.iVALID & ready_q;

  // One-hot write strobe for the bank addressed by the current sample.
  always_comb begin
    we_d         = '0;
    we_d[bank_d] = 1'b1;
  end

  // Loader FSM with registered handshake, status and RAM write outputs.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      we_q   <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.iSTART) begin
            state_q <= ST_LOAD;
            n_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept_d) begin
            we_q           <= we_d;
            data_q[bank_d] <= bus.iDATA;
            addr_q[bank_d] <= addr_d;
            n_q            <= n_q + NW'(1);
            if (n_q == N_LAST) begin
              // Last sample: its write and the done pulse share the next cycle.
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oREADY     = ready_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oDONE      = done_q;
  assign bus.oWE_0      = we_q[0];
  assign bus.oWE_1      = we_q[1];
  assign bus.oWE_2      = we_q[2];
  assign bus.oWE_3      = we_q[3];
  assign bus.oDATA_0    = data_q[0];
  assign bus.oDATA_1    = data_q[1];
  assign bus.oDATA_2    = data_q[2];
  assign bus.oDATA_3    = data_q[3];
  assign bus.oADDR_WR_0 = addr_q[0];
  assign bus.oADDR_WR_1 = addr_q[1];
  assign bus.oADDR_WR_2 = addr_q[2];
  assign bus.oADDR_WR_3 = addr_q[3];

endmodule

// File: tb/tb_fht_ram_loader.sv
// Testbench for fht_ram_loader (A_BIT=8, N=1024). Directed frames with a
// cycle-level reference model checked at every falling edge, plus
// hand-computed checks on captured bank contents and frame statistics.
// Address-mode expectations follow FHT_LOADER_BITREV_EN.
module tb_fht_ram_loader;

  localparam int D_BIT = fht_pkg::D_BIT_DEF;
  localparam int A_BIT = fht_pkg::A_BIT_DEF;
  localparam int NW    = A_BIT + 2;
  localparam int N     = fht_pkg::N_DEF;

  logic iCLK;
  logic iRESET;

  fht_ram_loader_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_ram_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [NW-1:0] tgt(input logic [NW-1:0] n);
    logic [NW-1:0] r;
`ifdef FHT_LOADER_BITREV_EN
    for (int i = 0; i < NW; i++) r[i] = n[NW-1-i];
`else
    r = n;
`endif
    return r;
  endfunction

  function automatic logic [D_BIT-1:0] dsel(input int k);
    case (k)
      0:       return bus.oDATA_0;
      1:       return bus.oDATA_1;
      2:       return bus.oDATA_2;
      default: return bus.oDATA_3;
    endcase
  endfunction

  function automatic logic [A_BIT-1:0] asel(input int k);
    case (k)
      0:       return bus.oADDR_WR_0;
      1:       return bus.oADDR_WR_1;
      2:       return bus.oADDR_WR_2;
      default: return bus.oADDR_WR_3;
    endcase
  endfunction

  // Reference model state (value expected on the outputs after the next edge).
  int               m_st   = 0;  // 0 idle, 1 load, 2 done
  int               m_n    = 0;
  logic             m_ld   = 1'b0;
  logic             m_done = 1'b0;
  logic [3:0]       m_we   = '0;
  int               m_bank = 0;
  logic [A_BIT-1:0] m_addr = '0;
  logic [D_BIT-1:0] m_data = '0;

  // Frame statistics and captured bank contents.
  int wr_cnt, busy_cnt, done_cnt, done_we_cnt, multi_cnt;
  logic [D_BIT-1:0] mem [4][2**A_BIT];

  task automatic clear_stats();
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_we_cnt = 0; multi_cnt = 0;
  endtask

  always @(negedge iCLK) begin
    logic [3:0]    we;
    logic [NW-1:0] idx;
    we = {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0};
    if (!iRESET) begin
      m_st = 0; m_n = 0; m_ld = 1'b0; m_done = 1'b0; m_we = '0;
    end
    check("ctl", 128'({we, bus.oREADY, bus.oBUSY, bus.oDONE}), 128'({m_we, m_ld, m_ld, m_done}));
    if (m_we != 4'b0) begin
      check("wdata", 128'(dsel(m_bank)), 128'(m_data));
      check("waddr", 128'(asel(m_bank)), 128'(m_addr));
    end
    if (iRESET) begin
      for (int k = 0; k < 4; k++) if (we[k]) mem[k][asel(k)] = dsel(k);
      wr_cnt += $countones(we);
      if ($countones(we) > 1) multi_cnt++;
      if (bus.oBUSY) busy_cnt++;
      if (bus.oDONE) begin
        done_cnt++;
        if (we != 4'b0) done_we_cnt++;
      end
      m_we = '0;
      m_done = 1'b0;
      case (m_st)
        0: if (bus.iSTART) begin m_st = 1; m_n = 0; end
        1: if (bus.iVALID) begin
             idx    = tgt(NW'(m_n));
             m_bank = int'(idx[1:0]);
             m_addr = idx[NW-1:2];
             m_data = bus.iDATA;
             m_we   = 4'b0001 << idx[1:0];
             if (m_n == N - 1) begin m_st = 2; m_done = 1'b1; end
             m_n++;
           end
        default: m_st = 0;
      endcase
      m_ld = (m_st == 1);
    end
  end

  // Start a frame, then feed nsamp samples; start_at re-pulses iSTART mid-frame.
  task automatic run_frame(input bit toggle, input int nsamp, input int data_xor, input int start_at);
    int n;
    int cyc;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    n = 0;
    cyc = 0;
    while (n < nsamp) begin
      bus.iVALID = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.iDATA  = D_BIT'(n ^ data_xor);
      bus.iSTART = (n == start_at);
      tick();
      if (bus.iVALID) n++;
      cyc++;
    end
    bus.iVALID = 1'b0;
    bus.iSTART = 1'b0;
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.oREADY, bus.oBUSY, bus.oDONE,
            bus.oWE_0, bus.oWE_1, bus.oWE_2, bus.oWE_3,
            bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_WR_2, bus.oADDR_WR_3,
            bus.oDATA_0 | bus.oDATA_1 | bus.oDATA_2 | bus.oDATA_3};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRESET = 1'b0;
    bus.iSTART = 1'b0;
    bus.iVALID = 1'b0;
    bus.iDATA  = '0;
    clear_stats();
    tick();
    tick();
    check("reset_outs", all_outs(), 128'(0));
    iRESET = 1'b1;
    tick();

    // iVALID while idle must not write; then full contiguous frame, data = n,
    // with a stray iSTART at n=10.
    bus.iVALID = 1'b1;
    bus.iDATA  = D_BIT'(5);
    for (int i = 0; i < 4; i++) tick();
    bus.iVALID = 1'b0;
    check("idle_writes", 128'(wr_cnt), 128'(0));
    check("idle_busy", 128'(busy_cnt), 128'(0));
    clear_stats();
    run_frame(1'b0, N, 0, 10);
    for (int i = 0; i < 3; i++) tick();
    check("a_writes", 128'(wr_cnt), 128'(1024));
    check("a_busy", 128'(busy_cnt), 128'(1024));
    check("a_done", 128'(done_cnt), 128'(1));
    check("a_done_we", 128'(done_we_cnt), 128'(1));
    check("a_multi_we", 128'(multi_cnt), 128'(0));
    check("a_b0_a0", 128'(mem[0][0]), 128'(0));
`ifdef FHT_LOADER_BITREV_EN
    check("a_n1", 128'(mem[0][128]), 128'(1));
    check("a_n128", 128'(mem[0][1]), 128'(128));
    check("a_n256", 128'(mem[2][0]), 128'(256));
    check("a_n512", 128'(mem[1][0]), 128'(512));
    check("a_n768", 128'(mem[3][0]), 128'(768));
`else
    check("a_n5", 128'(mem[1][1]), 128'(5));
    check("a_n6", 128'(mem[2][1]), 128'(6));
    check("a_n512", 128'(mem[0][128]), 128'(512));
    check("a_n1023", 128'(mem[3][255]), 128'(1023));
`endif

    // Toggling iVALID: 1024 writes spread over 2047 load cycles.
    clear_stats();
    run_frame(1'b1, N, 'h15555, -1);
    for (int i = 0; i < 3; i++) tick();
    check("b_writes", 128'(wr_cnt), 128'(1024));
    check("b_busy", 128'(busy_cnt), 128'(2047));
    check("b_done", 128'(done_cnt), 128'(1));
    check("b_multi_we", 128'(multi_cnt), 128'(0));
    check("b_first", 128'(mem[0][0]), 128'('h15555));
    check("b_last", 128'(mem[3][255]), 128'('h156AA));

    // Reset after 300 accepted samples: outputs clear at once, loader stays idle.
    clear_stats();
    run_frame(1'b0, 300, 0, -1);
    #1;
    iRESET = 1'b0;
    #1;
    check("midreset_outs", all_outs(), 128'(0));
    tick();
    tick();
    iRESET = 1'b1;
    clear_stats();
    bus.iVALID = 1'b1;
    bus.iDATA  = D_BIT'(7);
    for (int i = 0; i < 8; i++) tick();
    bus.iVALID = 1'b0;
    check("post_reset_ready", 128'(bus.oREADY), 128'(0));
    check("post_reset_writes", 128'(wr_cnt), 128'(0));
    check("post_reset_busy", 128'(busy_cnt), 128'(0));

    // A fresh iSTART loads a complete frame again.
    clear_stats();
    run_frame(1'b0, N, 'h0A5A5, -1);
    for (int i = 0; i < 3; i++) tick();
    check("c_writes", 128'(wr_cnt), 128'(1024));
    check("c_done", 128'(done_cnt), 128'(1));
    check("c_first", 128'(mem[0][0]), 128'('h0A5A5));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
